// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq : registered, handshaked ALU with sequential shifter
//
// Evolution of the 4-bit combinational ALU. It sits between the controller's
// decode stage and register-file writeback. Logic, add, subtract and
// add-with-carry ops complete in one cycle. Logical shifts are performed one
// bit per cycle. A persistent carry flag (c_flag) chains multi-word adds.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand/opcode valid
//   in_ready   block can accept an operation this cycle
//   a, b       operands (shifts use b[SHW-1:0] as the amount)
//   sel        opcode: 000 AND, 001 OR, 010 XOR, 011 ADD, 100 SUB,
//              101 ADC, 110 SHL, 111 SHR
//   out_valid  result/flags valid (held until out_ready)
//   out_ready  downstream accepts the result
//   out        result
//   carry_out  carry / no-borrow / last bit shifted out
//   zero_flag  out == 0
//   neg_flag   out[WIDTH-1]
//   ovf_flag   signed overflow for ADD/SUB/ADC, else 0
// ---------------------------------------------------------------------------
module alu_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       sel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             carry_out,
   output logic             zero_flag,
   output logic             neg_flag,
   output logic             ovf_flag
);

   localparam int SHW = $clog2(WIDTH);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_XOR = 3'b010;
   localparam logic [2:0] OP_ADD = 3'b011;
   localparam logic [2:0] OP_SUB = 3'b100;
   localparam logic [2:0] OP_ADC = 3'b101;
   localparam logic [2:0] OP_SHL = 3'b110;

   // control / result registers (reset)
   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic             carry_q, carry_d;
   logic             zero_q, zero_d;
   logic             neg_q, neg_d;
   logic             ovf_q, ovf_d;
   logic             c_flag_q, c_flag_d;

   // shifter working registers (always loaded before use, no reset needed)
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [SHW-1:0]   cnt_q, cnt_d;
   logic             shl_q, shl_d;
   logic             sc_q, sc_d;

   // single-cycle ALU
   logic [WIDTH:0]   sum_ext;
   logic [WIDTH:0]   diff_ext;
   logic [WIDTH-1:0] alu_res;
   logic             alu_c;
   logic             alu_v;

   // result load path shared by the one-cycle ops and the shifter
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             load_c;
   logic             load_v;

   logic             in_ready_c;
   logic             accept;
   logic             is_shift;

   assign in_ready  = in_ready_c;
   assign out_valid = (state_q == ST_DONE);
   assign out       = out_q;
   assign carry_out = carry_q;
   assign zero_flag = zero_q;
   assign neg_flag  = neg_q;
   assign ovf_flag  = ovf_q;

   always_comb begin
      // c_flag_q already reflects a result sitting in DONE, so a
      // back-to-back ADC chains off the result being consumed this cycle.
      sum_ext  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, (sel == OP_ADC) & c_flag_q};
      diff_ext = {1'b0, a} - {1'b0, b};
      alu_res  = '0;
      alu_c    = 1'b0;
      alu_v    = 1'b0;
      case (sel)
         OP_AND: alu_res = a & b;
         OP_OR:  alu_res = a | b;
         OP_XOR: alu_res = a ^ b;
         OP_ADD, OP_ADC: begin
            alu_res = sum_ext[WIDTH-1:0];
            alu_c   = sum_ext[WIDTH];
            alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res = diff_ext[WIDTH-1:0];
            // top bit of the extended difference is the borrow
            alu_c   = ~diff_ext[WIDTH];
            alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
         end
         default: ;
      endcase
   end

   always_comb begin
      in_ready_c = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
      accept     = in_valid && in_ready_c;
      is_shift   = sel[2] & sel[1];

      state_d  = state_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      shl_d    = shl_q;
      sc_d     = sc_q;
      load     = 1'b0;
      load_val = alu_res;
      load_c   = alu_c;
      load_v   = alu_v;

      case (state_q)
         ST_SHIFT: begin
            if (cnt_q != '0) begin
               if (shl_q) begin
                  acc_d = {acc_q[WIDTH-2:0], 1'b0};
                  sc_d  = acc_q[WIDTH-1];
               end else begin
                  acc_d = {1'b0, acc_q[WIDTH-1:1]};
                  sc_d  = acc_q[0];
               end
               cnt_d = cnt_q - SHW'(1);
            end else begin
               load     = 1'b1;
               load_val = acc_q;
               load_c   = sc_q;
               load_v   = 1'b0;
               state_d  = ST_DONE;
            end
         end
         ST_IDLE, ST_DONE: begin
            if (accept) begin
               if (is_shift) begin
                  state_d = ST_SHIFT;
                  acc_d   = a;
                  cnt_d   = b[SHW-1:0];
                  shl_d   = (sel == OP_SHL);
                  sc_d    = 1'b0;
               end else begin
                  load    = 1'b1;
                  state_d = ST_DONE;
               end
            end else if ((state_q == ST_DONE) && out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      out_d    = out_q;
      carry_d  = carry_q;
      zero_d   = zero_q;
      neg_d    = neg_q;
      ovf_d    = ovf_q;
      c_flag_d = c_flag_q;
      if (load) begin
         out_d    = load_val;
         carry_d  = load_c;
         zero_d   = (load_val == '0);
         neg_d    = load_val[WIDTH-1];
         ovf_d    = load_v;
         c_flag_d = load_c;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         out_q    <= '0;
         carry_q  <= 1'b0;
         zero_q   <= 1'b0;
         neg_q    <= 1'b0;
         ovf_q    <= 1'b0;
         c_flag_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         out_q    <= out_d;
         carry_q  <= carry_d;
         zero_q   <= zero_d;
         neg_q    <= neg_d;
         ovf_q    <= ovf_d;
         c_flag_q <= c_flag_d;
      end
   end

   always_ff @(posedge clk) begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      shl_q <= shl_d;
      sc_q  <= sc_d;
   end

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq : self-checking bench for alu_seq (WIDTH=8 and WIDTH=4 copies)
// ---------------------------------------------------------------------------
module tb_alu_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a, b;
   logic [2:0] sel;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out;
   logic       carry_out, zero_flag, neg_flag, ovf_flag;

   logic       iv4, ir4, ov4, ordy4;
   logic [3:0] a4, b4, out4;
   logic [2:0] sel4;
   logic       c4, z4, n4, v4;

   logic rand_rdy  = 1'b0;
   logic rdy_force = 1'b1;
   logic rnd_rdy   = 1'b1;
   assign out_ready = rand_rdy ? rnd_rdy : rdy_force;
   always @(posedge clk) begin
      #1;
      rnd_rdy = ($urandom_range(0, 3) != 0);
   end

   alu_seq #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
      .out(out), .carry_out(carry_out), .zero_flag(zero_flag),
      .neg_flag(neg_flag), .ovf_flag(ovf_flag)
   );

   alu_seq #(.WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
      .a(a4), .b(b4), .sel(sel4), .out_valid(ov4), .out_ready(ordy4),
      .out(out4), .carry_out(c4), .zero_flag(z4),
      .neg_flag(n4), .ovf_flag(v4)
   );

   int n_cmp = 0;
   int n_bad = 0;

   function automatic void chk(string name, int got, int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
      end
   endfunction

   // ---------------- reference model (8-bit) ----------------
   typedef struct {
      logic [7:0] r;
      logic       c;
      logic       z;
      logic       n;
      logic       v;
   } res_t;

   res_t q[$];
   logic mcf = 1'b0;

   function automatic res_t model(logic [2:0] s, logic [7:0] x, logic [7:0] y, logic cin);
      res_t e;
      int ux  = int'(x);
      int uy  = int'(y);
      int sx  = int'($signed(x));
      int sy  = int'($signed(y));
      int ci  = int'(cin);
      int amt = int'(y[2:0]);
      int t   = 0;
      int st  = 0;
      e.c = 1'b0;
      e.v = 1'b0;
      case (s)
         3'd0: t = ux & uy;
         3'd1: t = ux | uy;
         3'd2: t = ux ^ uy;
         3'd3: begin t = ux + uy;      st = sx + sy;      e.c = (t > 255); end
         3'd4: begin t = ux - uy;      st = sx - sy;      e.c = (ux >= uy); end
         3'd5: begin t = ux + uy + ci; st = sx + sy + ci; e.c = (t > 255); end
         3'd6: begin t = ux << amt; e.c = (amt > 0) && (t[8] == 1'b1); end
         default: begin t = ux >> amt; e.c = (amt > 0) && (((ux >> (amt - 1)) & 1) == 1); end
      endcase
      if (s == 3'd3 || s == 3'd4 || s == 3'd5) e.v = (st > 127) || (st < -128);
      e.r = t[7:0];
      e.z = (e.r == 8'h00);
      e.n = e.r[7];
      return e;
   endfunction

   // acceptance / consumption tracking
   always @(posedge clk) begin
      if (!rst_n) begin
         q.delete();
         mcf = 1'b0;
      end else begin
         if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
         if (in_valid && in_ready) begin
            res_t e;
            e = model(sel, a, b, mcf);
            q.push_back(e);
            mcf = e.c;
         end
      end
   end

   // compare DUT against the model every cycle the result is presented
   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         if (q.size() == 0) begin
            chk("unexpected_valid", 1, 0);
         end else begin
            chk("m_out",   int'(out),       int'(q[0].r));
            chk("m_carry", int'(carry_out), int'(q[0].c));
            chk("m_zero",  int'(zero_flag), int'(q[0].z));
            chk("m_neg",   int'(neg_flag),  int'(q[0].n));
            chk("m_ovf",   int'(ovf_flag),  int'(q[0].v));
         end
      end
   end

   task automatic issue(input logic [2:0] s, input logic [7:0] x, input logic [7:0] y);
      int n = 0;
      sel = s; a = x; b = y; in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk("accept_timeout", 0, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a = 8'($urandom); b = 8'($urandom); sel = 3'($urandom);
   endtask

   // cycles after the accept edge until out_valid
   task automatic wait_valid(output int cyc);
      cyc = 0;
      while (!out_valid && cyc < 64) begin
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   task automatic lit(string tag, logic [7:0] r, logic c, logic z, logic n, logic v);
      chk({tag, "_out"},   int'(out),       int'(r));
      chk({tag, "_carry"}, int'(carry_out), int'(c));
      chk({tag, "_zero"},  int'(zero_flag), int'(z));
      chk({tag, "_neg"},   int'(neg_flag),  int'(n));
      chk({tag, "_ovf"},   int'(ovf_flag),  int'(v));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      logic [3:0] e4;
      rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; sel = '0;
      iv4 = 1'b0; a4 = '0; b4 = '0; sel4 = '0; ordy4 = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", int'(out_valid), 0);
      lit("rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("rst_valid4", int'(ov4), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_in_ready", int'(in_ready), 1);

      // 1: ADD with carry-out and zero; hold under back-pressure
      rdy_force = 1'b0;
      issue(3'b011, 8'hFF, 8'h01);
      wait_valid(cyc);
      chk("t1_latency", cyc, 0);
      lit("t1", 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
      repeat (3) begin
         @(posedge clk);
         #1;
         chk("t1_hold_valid", int'(out_valid), 1);
         chk("t1_hold_ready", int'(in_ready), 0);
         lit("t1_hold", 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
      end
      rdy_force = 1'b1;
      @(posedge clk);
      #1;
      chk("t1_idle", int'(out_valid), 0);

      // 2: signed overflow and SUB with borrow
      issue(3'b011, 8'h7F, 8'h01);
      lit("t2_add", 8'h80, 1'b0, 1'b0, 1'b1, 1'b1);
      issue(3'b100, 8'h05, 8'h07);
      lit("t2_sub", 8'hFE, 1'b0, 1'b0, 1'b1, 1'b0);

      // 3: multi-word add, back-to-back with no bubbles
      issue(3'b011, 8'hFF, 8'h01);
      chk("t3_v0", int'(out_valid), 1);
      lit("t3_add", 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
      issue(3'b101, 8'h00, 8'h00);
      chk("t3_v1", int'(out_valid), 1);
      lit("t3_adc1", 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
      issue(3'b101, 8'h00, 8'h00);
      chk("t3_v2", int'(out_valid), 1);
      lit("t3_adc2", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);

      // 4: shifts and their latency
      issue(3'b110, 8'h81, 8'h03);
      wait_valid(cyc);
      chk("t4_shl_lat", cyc, 4);
      lit("t4_shl", 8'h08, 1'b0, 1'b0, 1'b0, 1'b0);
      issue(3'b111, 8'h81, 8'h01);
      wait_valid(cyc);
      chk("t4_shr_lat", cyc, 2);
      lit("t4_shr", 8'h40, 1'b1, 1'b0, 1'b0, 1'b0);
      issue(3'b110, 8'h81, 8'h00);
      wait_valid(cyc);
      chk("t4_sh0_lat", cyc, 1);
      lit("t4_sh0", 8'h81, 1'b0, 1'b0, 1'b1, 1'b0);

      // 5: asynchronous reset in the third shift cycle
      issue(3'b110, 8'h01, 8'h07);
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      rst_n = 1'b0;
      #1;
      chk("t5_valid", int'(out_valid), 0);
      lit("t5_rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("t5_in_ready", int'(in_ready), 1);
      issue(3'b101, 8'h01, 8'h01);
      lit("t5_adc", 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);

      // randomized traffic with random back-pressure
      rand_rdy = 1'b1;
      repeat (400) begin
         int gap = $urandom_range(0, 2);
         repeat (gap) begin
            @(posedge clk);
            #1;
         end
         issue(3'($urandom), 8'($urandom), 8'($urandom));
      end
      rand_rdy = 1'b0;
      rdy_force = 1'b1;
      cyc = 0;
      while (q.size() > 0 && cyc < 200) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      chk("drain", q.size(), 0);

      // 6: exhaustive logic-op sweep on the 4-bit instance
      for (int op = 0; op < 3; op++) begin
         for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
               sel4 = 3'(op); a4 = 4'(x); b4 = 4'(y); iv4 = 1'b1;
               @(negedge clk);
               chk("w4_in_ready", int'(ir4), 1);
               @(posedge clk);
               #1;
               iv4 = 1'b0;
               e4 = (op == 0) ? 4'(x & y) : (op == 1) ? 4'(x | y) : 4'(x ^ y);
               chk("w4_valid", int'(ov4), 1);
               chk("w4_out",   int'(out4), int'(e4));
               chk("w4_carry", int'(c4), 0);
               chk("w4_ovf",   int'(v4), 0);
               chk("w4_zero",  int'(z4), (e4 == 4'h0) ? 1 : 0);
               chk("w4_neg",   int'(n4), int'(e4[3]));
            end
         end
      end

      @(posedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
